apb_master_arb: RTL and testbench

Shares one APB master port between `NUM_REQ` internal requesters (register-model sequencer, debug/backdoor path, etc.) and sequences each granted command through the APB SETUP/ACCESS protocol. Round-robin arbitration, one outstanding transfer, PREADY wait states with timeout, per-requester completion with slave-error reporting. Sits between the requester blocks and the APB signal bundle (`PADDR`, `PSELx`, `PENABLE`, `PSTRB`, `PWRITE`, `PWDATA`, `PRDATA`, `PREADY`, `PSLVERR`).

---
 rtl/apb_arb_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/apb_master_arb.sv | 117 +++++++++++
 tb/tb_apb_master_arb.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared types for the APB master arbiter.
//   apb_state_e : transfer sequencer states (IDLE, SETUP, ACCESS)
//   apb_cmd_t   : latched command (addr, write, wdata, strb)
//   owner_w()   : width of an encoded requester index
package apb_arb_pkg;
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

    typedef struct packed {
        logic [APB_ADDR_W-1:0]   addr;
        logic                    write;
        logic [APB_DATA_W-1:0]   wdata;
        logic [APB_DATA_W/8-1:0] strb;
    } apb_cmd_t;

    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over a request vector.
//   req   in  N   request lines
//   ptr   in  IW  highest-priority index for this pick
//   grant out N   one-hot grant (zero when no request)
//   idx   out IW  encoded index of the granted line
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int IW = owner_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    logic found;

    // Scan from ptr upward with wrap; first asserted request wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                grant[(int'(ptr) + k) % N] = 1'b1;
                idx = IW'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/apb_master_arb.sv
// apb_master_arb: round-robin sharing of one APB master port among NUM_REQ requesters.
//   PCLK, PRESET                     clock, asynchronous active-high reset
//   req_valid/req_ready              per-requester command handshake
//   req_addr/req_write/req_wdata/req_strb  packed per-requester command payloads
//   rsp_valid/rsp_rdata/rsp_err      registered one-cycle completion to the owner
//   PADDR/PSELx/PENABLE/PSTRB/PWRITE/PWDATA  APB master drive
//   PRDATA/PREADY/PSLVERR            APB slave response
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                        PCLK,
    input  logic                        PRESET,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0] req_strb,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic [ADDR_W-1:0]           PADDR,
    output logic                        PSELx,
    output logic                        PENABLE,
    output logic [DATA_W/8-1:0]         PSTRB,
    output logic                        PWRITE,
    output logic [DATA_W-1:0]           PWDATA,
    input  logic [DATA_W-1:0]           PRDATA,
    input  logic                        PREADY,
    input  logic                        PSLVERR
);
    localparam int IW = owner_w(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int SW = DATA_W / 8;

    apb_state_e       state;
    apb_cmd_t         cmd;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    idx;
    logic [NUM_REQ-1:0] grant;
    logic [CW-1:0]    wait_cnt;
    logic             done;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (idx)
    );

    // Accept only while idle; reset also masks the handshake so nothing is taken during reset.
    assign req_ready = (state == IDLE && !PRESET) ? grant : '0;

    // PREADY in the last counted wait cycle still completes normally, so it is checked first.
    assign done = PREADY || (wait_cnt == CW'(TIMEOUT - 1));

    assign PADDR  = ADDR_W'(cmd.addr);
    assign PWRITE = cmd.write;
    assign PWDATA = DATA_W'(cmd.wdata);
    assign PSTRB  = SW'(cmd.strb);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            cmd       <= '0;
            rr_ptr    <= '0;
            owner     <= '0;
            wait_cnt  <= '0;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        cmd <= '{addr:  APB_ADDR_W'(req_addr[int'(idx)*ADDR_W +: ADDR_W]),
                                 write: req_write[idx],
                                 wdata: APB_DATA_W'(req_wdata[int'(idx)*DATA_W +: DATA_W]),
                                 strb:  (APB_DATA_W/8)'(req_strb[int'(idx)*SW +: SW])};
                        owner  <= idx;
                        rr_ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
                        PSELx  <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        rsp_valid <= NUM_REQ'(1) << owner;
                        rsp_err   <= PREADY ? PSLVERR : 1'b1;
                        rsp_rdata <= (PREADY && !cmd.write) ? PRDATA : '0;
                        PSELx     <= 1'b0;
                        PENABLE   <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb: randomized scoreboard bench with an APB slave model and round-robin reference.
module tb_apb_master_arb;
    localparam int TIMEOUT = 16;

    typedef struct {
        int          wt;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } plan_t;

    typedef struct {
        int          owner;
        logic [31:0] rdata;
        logic        err;
        int          nacc;
    } exp_t;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_addr = '0;
    logic [1:0]  req_write = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_strb = '0;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] PADDR;
    logic        PSELx;
    logic        PENABLE;
    logic [3:0]  PSTRB;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;
    int acc_cnt = 0;
    plan_t slv_q[$];
    exp_t  exp_q[$];
    plan_t cur;

    apb_master_arb #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE), .PSTRB(PSTRB),
        .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic plan_t rand_plan();
        plan_t q;
        q.wt    = $urandom_range(0, 18);
        q.err   = 1'($urandom);
        q.rdata = $urandom;
        q.addr  = $urandom & 32'hFFFF_FFFC;
        q.write = 1'($urandom);
        q.wdata = $urandom;
        q.strb  = 4'($urandom);
        return q;
    endfunction

    // Reference: a slave that never answers within TIMEOUT access cycles yields an error with zero data;
    // otherwise the slave's PSLVERR is reported and read data only comes back for reads.
    task automatic expect_txn(input int r, input plan_t q);
        bit   to;
        exp_t e;
        to = q.wt >= TIMEOUT;
        slv_q.push_back(q);
        e.owner = r;
        e.rdata = (q.write || to) ? 32'h0 : q.rdata;
        e.err   = to ? 1'b1 : q.err;
        e.nacc  = to ? TIMEOUT : q.wt + 1;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int r, input plan_t q);
        req_addr[r*32 +: 32]  = q.addr;
        req_write[r]          = q.write;
        req_wdata[r*32 +: 32] = q.wdata;
        req_strb[r*4 +: 4]    = q.strb;
    endtask

    task automatic wait_drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 200) begin
            @(negedge PCLK);
            c++;
        end
        chk("drain", 64'(exp_q.size()), 0);
    endtask

    // Requesters in mask raise valid together and hold until accepted; service order follows
    // round-robin from the model pointer.
    task automatic run_round(input logic [1:0] mask, input plan_t p [2]);
        int order[$];
        int cyc;
        logic [1:0] pend, acc;
        for (int k = 0; k < 2; k++) begin
            int j;
            j = (model_ptr + k) % 2;
            if (mask[j]) order.push_back(j);
        end
        foreach (order[n]) expect_txn(order[n], p[order[n]]);
        model_ptr = (order[order.size()-1] + 1) % 2;
        @(posedge PCLK); #1;
        for (int i = 0; i < 2; i++) if (mask[i]) drive(i, p[i]);
        req_valid = mask;
        pend = mask;
        cyc = 0;
        while (pend != 0 && cyc < 400) begin
            @(negedge PCLK);
            chk("ready_onehot", 64'($onehot0(req_ready)), 1);
            acc = req_ready & req_valid;
            @(posedge PCLK); #1;
            req_valid = req_valid & ~acc;
            pend = pend & ~acc;
            cyc++;
        end
        chk("accept_all", 64'(pend), 0);
        wait_drain();
    endtask

    // APB slave model: takes its response plan at SETUP, checks the command is held, answers per plan.
    always @(negedge PCLK) begin
        if (PRESET || !PSELx) begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
        end else if (!PENABLE) begin
            PREADY = 1'b0;
            if (slv_q.size() == 0) begin
                chk("setup_without_cmd", 1, 0);
            end else begin
                cur = slv_q.pop_front();
                acc_cnt = 0;
                chk("paddr", 64'(PADDR), 64'(cur.addr));
                chk("pwrite", 64'(PWRITE), 64'(cur.write));
            end
        end else begin
            acc_cnt++;
            chk("paddr_hold", 64'(PADDR), 64'(cur.addr));
            chk("pwrite_hold", 64'(PWRITE), 64'(cur.write));
            chk("pwdata_hold", 64'(PWDATA), 64'(cur.wdata));
            chk("pstrb_hold", 64'(PSTRB), 64'(cur.strb));
            if (acc_cnt == cur.wt + 1) begin
                PREADY  = 1'b1;
                PRDATA  = cur.rdata;
                PSLVERR = cur.err;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom);
            end
        end
    end

    // Scoreboard monitor
    always @(negedge PCLK) begin
        if (!PRESET && rsp_valid != 0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_owner", 64'(rsp_valid), 64'(2'b01 << e.owner));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                chk("access_cycles", 64'(acc_cnt), 64'(e.nacc));
                chk("psel_low_at_rsp", 64'(PSELx), 0);
            end
        end
    end

    initial begin
        plan_t p;
        plan_t pp [2];
        // Reset state, with requests present to confirm nothing is accepted
        req_valid = 2'b11;
        repeat (3) @(negedge PCLK);
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_psel", 64'(PSELx), 0);
        chk("rst_penable", 64'(PENABLE), 0);
        chk("rst_paddr", 64'(PADDR), 0);
        chk("rst_pwdata", 64'(PWDATA), 0);
        req_valid = 2'b00;
        PRESET = 1'b0;

        // Single read with exact cycle timing
        p = '{wt: 0, err: 1'b0, rdata: 32'hDEADBEEF, addr: 32'h10, write: 1'b0, wdata: 32'h0, strb: 4'h0};
        expect_txn(0, p);
        model_ptr = 1;
        @(posedge PCLK); #1;
        drive(0, p);
        req_valid = 2'b01;
        @(negedge PCLK);
        chk("t0_ready", 64'(req_ready), 2'b01);
        @(posedge PCLK); #1;
        req_valid = 2'b00;
        @(negedge PCLK);
        chk("t1_psel", 64'({PSELx, PENABLE}), 2'b10);
        @(negedge PCLK);
        chk("t2_penable", 64'({PSELx, PENABLE}), 2'b11);
        @(negedge PCLK);
        chk("t3_rsp_valid", 64'(rsp_valid), 2'b01);
        chk("t3_rdata", 64'(rsp_rdata), 64'h0DEADBEEF);
        chk("t3_err", 64'(rsp_err), 0);
        wait_drain();

        // Write with four wait states
        pp[0] = '{wt: 4, err: 1'b0, rdata: 32'h1234_5678, addr: 32'h40, write: 1'b1, wdata: 32'hCAFE_F00D, strb: 4'h3};
        pp[1] = rand_plan();
        run_round(2'b01, pp);

        // Both requesters contending: grants alternate
        for (int r = 0; r < 4; r++) begin
            pp[0] = rand_plan();
            pp[1] = rand_plan();
            pp[0].wt = r;
            pp[1].wt = 1;
            run_round(2'b11, pp);
        end

        // Timeout, PREADY on the final counted cycle, and slave error
        pp[0] = rand_plan(); pp[0].wt = 99;
        run_round(2'b01, pp);
        pp[1] = rand_plan(); pp[1].wt = TIMEOUT - 1; pp[1].err = 1'b0;
        run_round(2'b10, pp);
        pp[0] = rand_plan(); pp[0].wt = 0; pp[0].err = 1'b1;
        run_round(2'b01, pp);

        // A requester withdrawing before acceptance gets nothing
        p = rand_plan();
        p.wt = 5;
        expect_txn(0, p);
        model_ptr = 1;
        @(posedge PCLK); #1;
        drive(0, p);
        req_valid = 2'b01;
        @(negedge PCLK);
        chk("wd_ready0", 64'(req_ready), 2'b01);
        @(posedge PCLK); #1;
        req_valid = 2'b10;
        repeat (3) begin
            @(negedge PCLK);
            chk("wd_busy_ready", 64'(req_ready), 0);
        end
        @(posedge PCLK); #1;
        req_valid = 2'b00;
        wait_drain();
        repeat (5) @(negedge PCLK);

        // Reset during ACCESS aborts without a response
        p = rand_plan();
        p.wt = 99;
        slv_q.push_back(p);
        @(posedge PCLK); #1;
        drive(0, p);
        req_valid = 2'b01;
        @(negedge PCLK);
        chk("ab_ready", 64'(req_ready), 2'b01);
        @(posedge PCLK); #1;
        req_valid = 2'b00;
        repeat (4) @(negedge PCLK);
        chk("ab_in_access", 64'({PSELx, PENABLE}), 2'b11);
        PRESET = 1'b1;
        #1;
        chk("ab_psel_drop", 64'({PSELx, PENABLE}), 2'b00);
        exp_q.delete();
        slv_q.delete();
        repeat (2) @(negedge PCLK);
        chk("ab_no_rsp", 64'(rsp_valid), 0);
        PRESET = 1'b0;
        model_ptr = 0;
        pp[0] = rand_plan();
        pp[1] = rand_plan();
        run_round(2'b11, pp);

        // Randomized traffic
        for (int n = 0; n < 25; n++) begin
            logic [1:0] m;
            m = 2'($urandom_range(1, 3));
            pp[0] = rand_plan();
            pp[1] = rand_plan();
            run_round(m, pp);
        end

        repeat (3) @(negedge PCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
